// File: rtl/data_mem_responder.sv
// Gumnut data-bus RAM responder: cyc/stb/we/ack handshake with WAIT_STATES wait states.
// Optional macro DMEM_RANGE_CHECK_EN adds err_o and blocks accesses at or above DEPTH.
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_cyc_i,
    input  logic              data_stb_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_adr_i,
    input  logic [DATA_W-1:0] data_dat_i,
    output logic [DATA_W-1:0] data_dat_o,
    output logic              data_ack_o
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic              err_o
`endif
);

    localparam int         IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   wdat_q;
    logic                we_q;
    logic                ack_q;
    logic [DATA_W-1:0]   rdata_q;
`ifdef DMEM_RANGE_CHECK_EN
    logic                err_q;
`endif

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                req;
    logic                enter_ack;
    logic [ADDR_W-1:0]   op_adr;
    logic [DATA_W-1:0]   op_dat;
    logic                op_we;
    logic                op_ok;
    logic [IDX_W-1:0]    op_idx;
    logic                unused_adr_bits;

    assign req = data_cyc_i & data_stb_i;

    // With zero wait states the RAM access happens on the accepting edge,
    // so the operands come straight from the bus instead of the latches.
    always_comb begin
        enter_ack = 1'b0;
        op_adr    = adr_q;
        op_dat    = wdat_q;
        op_we     = we_q;
        if (state_q == S_IDLE) begin
            enter_ack = req && (WS == 4'd0);
            op_adr    = data_adr_i;
            op_dat    = data_dat_i;
            op_we     = data_we_i;
        end else if (state_q == S_WAIT) begin
            enter_ack = req && (cnt_q == 4'd1);
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    assign op_ok = ({1'b0, op_adr} < (ADDR_W+1)'(DEPTH));
`else
    assign op_ok = 1'b1;
`endif

    assign op_idx          = op_adr[IDX_W-1:0];
    assign unused_adr_bits = ^op_adr;

    always_ff @(posedge clk) begin
        if (!rst && enter_ack && op_we && op_ok) begin
            mem[op_idx] <= op_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
`ifdef DMEM_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            ack_q <= enter_ack;
`ifdef DMEM_RANGE_CHECK_EN
            err_q <= enter_ack && !op_ok;
`endif
            if (enter_ack && !op_we) begin
                rdata_q <= op_ok ? mem[op_idx] : '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        adr_q   <= data_adr_i;
                        wdat_q  <= data_dat_i;
                        we_q    <= data_we_i;
                        cnt_q   <= WS;
                        state_q <= (WS == 4'd0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    state_q <= data_stb_i ? S_HOLD : S_IDLE;
                end
                S_HOLD: begin
                    // The core keeps stb up through write-back; wait it out.
                    if (!req) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_dat_o = rdata_q;
    assign data_ack_o = ack_q;
`ifdef DMEM_RANGE_CHECK_EN
    assign err_o      = err_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (W=1/D=256, W=0/D=256, W=3/D=64)
// exercised by a vector table plus hand sequences for abort, hold, reset and range cases.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;
    logic [2:0]      cyc, stb, we;
    logic [2:0][7:0] adr, wdat, rdat;
    logic [2:0]      ack;
    logic [7:0]      rdat0, rdat1, rdat2;
    logic            ack0, ack1, ack2;
`ifdef DMEM_RANGE_CHECK_EN
    logic            err0, err1, err2;
    logic [2:0]      err;
    assign err = {err2, err1, err0};
`endif

    int total = 0;
    int bad   = 0;
    int lat_exp [3] = '{2, 1, 4};

    assign rdat = {rdat2, rdat1, rdat0};
    assign ack  = {ack2, ack1, ack0};

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(1)) u_dut0 (
        .clk(clk), .rst(rst), .data_cyc_i(cyc[0]), .data_stb_i(stb[0]), .data_we_i(we[0]),
        .data_adr_i(adr[0]), .data_dat_i(wdat[0]), .data_dat_o(rdat0), .data_ack_o(ack0)
`ifdef DMEM_RANGE_CHECK_EN
        , .err_o(err0)
`endif
    );

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .rst(rst), .data_cyc_i(cyc[1]), .data_stb_i(stb[1]), .data_we_i(we[1]),
        .data_adr_i(adr[1]), .data_dat_i(wdat[1]), .data_dat_o(rdat1), .data_ack_o(ack1)
`ifdef DMEM_RANGE_CHECK_EN
        , .err_o(err1)
`endif
    );

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_STATES(3)) u_dut2 (
        .clk(clk), .rst(rst), .data_cyc_i(cyc[2]), .data_stb_i(stb[2]), .data_we_i(we[2]),
        .data_adr_i(adr[2]), .data_dat_i(wdat[2]), .data_dat_o(rdat2), .data_ack_o(ack2)
`ifdef DMEM_RANGE_CHECK_EN
        , .err_o(err2)
`endif
    );

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic start(input int k, input logic w, input logic [7:0] a, input logic [7:0] d);
        cyc[k]  = 1'b1;
        stb[k]  = 1'b1;
        we[k]   = w;
        adr[k]  = a;
        wdat[k] = d;
    endtask

    task automatic stop(input int k);
        cyc[k] = 1'b0;
        stb[k] = 1'b0;
    endtask

    task automatic wait_ack(input int k, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ack[k]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_acks(input int k, input int cycles, output int acks);
        acks = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (ack[k]) acks++;
        end
    endtask

    // Full transaction; called at posedge+1 with the instance idle.
    task automatic access(input int k, input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] exp_dat, input logic exp_err);
        int n;
        start(k, w, a, d);
        wait_ack(k, n);
        $display("txn dut%0d %s adr=%02h wdat=%02h lat=%0d rdat=%02h", k, w ? "wr" : "rd",
                 a, d, n, rdat[k]);
        chk($sformatf("latency dut%0d adr %02h", k, a), n, lat_exp[k]);
        chk($sformatf("rdat dut%0d adr %02h", k, a), {24'd0, rdat[k]}, {24'd0, exp_dat});
`ifdef DMEM_RANGE_CHECK_EN
        chk($sformatf("err dut%0d adr %02h", k, a), {31'd0, err[k]}, {31'd0, exp_err});
`else
        if (exp_err) $display("note: range error expected only with range check");
`endif
        stop(k);
        @(posedge clk);
        #1;
        chk($sformatf("ack pulse dut%0d adr %02h", k, a), {31'd0, ack[k]}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acks;
        logic range_on;
`ifdef DMEM_RANGE_CHECK_EN
        range_on = 1'b1;
`else
        range_on = 1'b0;
`endif
        tbl[0]  = '{1'b1, 8'h10, 8'hA5, 8'h00};
        tbl[1]  = '{1'b0, 8'h10, 8'h00, 8'hA5};
        tbl[2]  = '{1'b1, 8'h05, 8'h3C, 8'hA5};
        tbl[3]  = '{1'b0, 8'h05, 8'h00, 8'h3C};
        tbl[4]  = '{1'b1, 8'h06, 8'h77, 8'h3C};
        tbl[5]  = '{1'b0, 8'h06, 8'h00, 8'h77};
        tbl[6]  = '{1'b1, 8'hFF, 8'h01, 8'h77};
        tbl[7]  = '{1'b0, 8'hFF, 8'h00, 8'h01};
        tbl[8]  = '{1'b1, 8'h00, 8'hEE, 8'h01};
        tbl[9]  = '{1'b0, 8'h00, 8'h00, 8'hEE};
        tbl[10] = '{1'b0, 8'h10, 8'h00, 8'hA5};

        rst  = 1'b1;
        cyc  = '0;
        stb  = '0;
        we   = '0;
        adr  = '0;
        wdat = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset ack dut%0d", k), {31'd0, ack[k]}, 32'd0);
            chk($sformatf("reset rdat dut%0d", k), {24'd0, rdat[k]}, 32'd0);
`ifdef DMEM_RANGE_CHECK_EN
            chk($sformatf("reset err dut%0d", k), {31'd0, err[k]}, 32'd0);
`endif
        end

        // Table: one wait state, reads/writes incl. read-data hold across writes.
        for (int i = 0; i < 11; i++) begin
            access(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp, 1'b0);
        end

        // Bus changes after acceptance are ignored.
        start(0, 1'b0, 8'h05, 8'h00);
        @(posedge clk);
        #1;
        we[0]   = 1'b1;
        adr[0]  = 8'h10;
        wdat[0] = 8'h00;
        wait_ack(0, n);
        chk("latched lat", n, 1);
        chk("latched rdat", {24'd0, rdat[0]}, 32'h3C);
        stop(0);
        @(posedge clk);
        #1;
        access(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);

        // Zero wait states; stb held into write-back gives one ack then HOLD.
        access(1, 1'b1, 8'h33, 8'h5C, 8'h00, 1'b0);
        start(1, 1'b0, 8'h33, 8'h00);
        wait_ack(1, n);
        chk("hold lat", n, 1);
        chk("hold rdat", {24'd0, rdat[1]}, 32'h5C);
        count_acks(1, 3, acks);
        chk("hold extra acks", acks, 0);
        stop(1);
        @(posedge clk);
        #1;
        chk("hold release ack", {31'd0, ack[1]}, 32'd0);
        access(1, 1'b0, 8'h33, 8'h00, 8'h5C, 1'b0);

        // Three wait states; strobe dropped mid-wait aborts the write.
        access(2, 1'b1, 8'h20, 8'h42, 8'h00, 1'b0);
        access(2, 1'b0, 8'h20, 8'h00, 8'h42, 1'b0);
        start(2, 1'b1, 8'h20, 8'h99);
        repeat (2) @(posedge clk);
        #1;
        stb[2] = 1'b0;
        count_acks(2, 6, acks);
        chk("abort acks", acks, 0);
        cyc[2] = 1'b0;
        @(posedge clk);
        #1;
        access(2, 1'b0, 8'h20, 8'h00, 8'h42, 1'b0);

        // Asynchronous reset in the middle of a write wait.
        start(2, 1'b1, 8'h20, 8'h13);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst ack dut2", {31'd0, ack[2]}, 32'd0);
        chk("rst rdat dut2", {24'd0, rdat[2]}, 32'd0);
        chk("rst rdat dut0", {24'd0, rdat[0]}, 32'd0);
        @(negedge clk);
        stop(2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        access(2, 1'b0, 8'h20, 8'h00, 8'h42, 1'b0);
        access(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);

        // DEPTH=64: 0x48 aliases to 0x08 unless range checking blocks it.
        access(2, 1'b1, 8'h08, 8'h5A, 8'h42, 1'b0);
        access(2, 1'b1, 8'h48, 8'h11, 8'h42, range_on);
        access(2, 1'b0, 8'h08, 8'h00, range_on ? 8'h5A : 8'h11, 1'b0);
`ifdef DMEM_RANGE_CHECK_EN
        access(2, 1'b0, 8'h48, 8'h00, 8'h00, 1'b1);
        access(2, 1'b0, 8'h08, 8'h00, 8'h5A, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
